obc_shift_accumulator: RTL and testbench

OBC_SHIFT_ACCUMULATOR -- requirements
Module: obc_shift_accumulator

---
 rtl/obc_shift_accumulator_pkg.sv | 15 +
 rtl/obc_slice_adder.sv | 30 +++
 rtl/obc_shift_accumulator.sv | 104 ++++++++++
 tb/tb_obc_shift_accumulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/obc_shift_accumulator_pkg.sv
// Shared definitions for the OBC shift-accumulator slice: FSM states,
// default sizing and the ROM word width.
package obc_shift_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } obc_state_t;

    localparam int unsigned DEF_B     = 16;
    localparam int unsigned DEF_ACC_W = 40;
    localparam int unsigned ROM_W     = 32;

endpackage

// File: rtl/obc_slice_adder.sv
// Combinational adder tree: sign-extends eight signed ROM partial sums to
// ACC_W bits and adds them. ACC_W >= ROM_W + 3 keeps the sum overflow-free.
module obc_slice_adder
    import obc_shift_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
)(
    input  logic [ROM_W-1:0] in0,
    input  logic [ROM_W-1:0] in1,
    input  logic [ROM_W-1:0] in2,
    input  logic [ROM_W-1:0] in3,
    input  logic [ROM_W-1:0] in4,
    input  logic [ROM_W-1:0] in5,
    input  logic [ROM_W-1:0] in6,
    input  logic [ROM_W-1:0] in7,
    output logic [ACC_W-1:0] sum
);

    logic [7:0][ROM_W-1:0] words;

    // Sign-extend each partial sum and accumulate the eight terms.
    always_comb begin
        words = {in7, in6, in5, in4, in3, in2, in1, in0};
        sum   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum = sum + {{(ACC_W-ROM_W){words[i][ROM_W-1]}}, words[i]};
        end
    end

endmodule

// File: rtl/obc_shift_accumulator.sv
// Offset-binary-coding shift accumulator: starts from the offset term,
// adds one bit-slice sum per accepted slice (LSB first) with a one-bit
// arithmetic right shift, and subtracts the final sign slice.
module obc_shift_accumulator
    import obc_shift_accumulator_pkg::*;
#(
    parameter int unsigned B     = DEF_B,
    parameter int unsigned ACC_W = DEF_ACC_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROM_W-1:0] offset,
    input  logic             slice_valid,
    input  logic [ROM_W-1:0] in0,
    input  logic [ROM_W-1:0] in1,
    input  logic [ROM_W-1:0] in2,
    input  logic [ROM_W-1:0] in3,
    input  logic [ROM_W-1:0] in4,
    input  logic [ROM_W-1:0] in5,
    input  logic [ROM_W-1:0] in6,
    input  logic [ROM_W-1:0] in7,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             result_valid
);

    localparam int unsigned CNT_W = (B > 1) ? $clog2(B) : 1;

    obc_state_t              state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] slice_sum;
    logic signed [ACC_W-1:0] acc_plus;
    logic [CNT_W-1:0]        cnt;
    logic                    load;
    logic                    step;
    logic                    last;

    obc_slice_adder #(
        .ACC_W (ACC_W)
    ) u_slice_adder (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .in4 (in4),
        .in5 (in5),
        .in6 (in6),
        .in7 (in7),
        .sum (slice_sum)
    );

    // Control decode: accepted start, accepted slice, final sign slice.
    always_comb begin
        load     = start && (state != ACC);
        step     = (state == ACC) && slice_valid;
        last     = step && (cnt == '0);
        acc_plus = acc + slice_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE falls back to IDLE unless restarted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = ACC;
            ACC:     if (last) state_nxt = DONE;
            DONE:    state_nxt = load ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load offset, shift-accumulate slices, subtract sign slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (load) begin
            acc <= {{(ACC_W-ROM_W){offset[ROM_W-1]}}, offset};
            cnt <= CNT_W'(B - 1);
        end else if (last) begin
            result <= acc - slice_sum;
        end else if (step) begin
            acc <= acc_plus >>> 1;
            cnt <= cnt - 1'b1;
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy         = (state == ACC);
        result_valid = (state == DONE);
    end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Self-checking bench for obc_shift_accumulator: random slice data checked
// against an arithmetic reference of the OBC recurrence.
module tb_obc_shift_accumulator;

    localparam int unsigned B     = 16;
    localparam int unsigned ACC_W = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      offset;
    logic             slice_valid;
    logic [31:0]      d [8];
    logic             busy;
    logic [ACC_W-1:0] result;
    logic             result_valid;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [31:0]      sl [B][8];
    logic [ACC_W-1:0] last_exp;

    always #5 clk = ~clk;

    obc_shift_accumulator #(
        .B     (B),
        .ACC_W (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .offset       (offset),
        .slice_valid  (slice_valid),
        .in0          (d[0]),
        .in1          (d[1]),
        .in2          (d[2]),
        .in3          (d[3]),
        .in4          (d[4]),
        .in5          (d[5]),
        .in6          (d[6]),
        .in7          (d[7]),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 8; i++) d[i] = $urandom;
    endtask

    // Value of one bit-slice: plain signed sum of its eight words.
    function automatic longint slice_val(input int k);
        longint s = 0;
        for (int i = 0; i < 8; i++) s += longint'($signed(sl[k][i]));
        return s;
    endfunction

    function automatic longint floor_half(input longint x);
        longint q = x / 2;
        if (x < 0 && (x % 2) != 0) q -= 1;
        return q;
    endfunction

    // Reference: offset, then B-1 add-and-halve (floor) steps, minus sign slice.
    function automatic logic [ACC_W-1:0] model(input logic [31:0] off);
        longint      a;
        logic [63:0] r;
        a = longint'($signed(off));
        for (int k = 0; k < int'(B) - 1; k++) a = floor_half(a + slice_val(k));
        r = 64'(a - slice_val(int'(B) - 1));
        return r[ACC_W-1:0];
    endfunction

    // mode 0: all zero, 1: full-range random, 2: small signed random
    task automatic fill(input int mode);
        for (int k = 0; k < int'(B); k++)
            for (int i = 0; i < 8; i++)
                case (mode)
                    0:       sl[k][i] = '0;
                    1:       sl[k][i] = $urandom;
                    default: sl[k][i] = 32'($signed(int'($urandom_range(0, 510)) - 255));
                endcase
    endtask

    // One accumulation; leaves the DUT in DONE (result_valid high).
    task automatic run_op(input logic [31:0] off, input int gap_at, input int gap_len,
                          input bit restart_mid, input string tag);
        logic [ACC_W-1:0] exp;
        bit               early;
        exp         = model(off);
        start       = 1'b1;
        offset      = off;
        slice_valid = 1'b0;
        tick();
        start  = 1'b0;
        offset = $urandom;
        early  = 1'b0;
        check({tag, ":busy"}, 64'(busy), 64'(1));
        for (int k = 0; k < int'(B); k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    slice_valid = 1'b0;
                    scramble_inputs();
                    tick();
                    if (result_valid) early = 1'b1;
                end
            end
            slice_valid = 1'b1;
            d           = sl[k];
            start       = restart_mid && (k == 3);
            if (restart_mid) offset = $urandom;
            tick();
            start = 1'b0;
            if (k < int'(B) - 1 && result_valid) early = 1'b1;
        end
        slice_valid = 1'b0;
        scramble_inputs();
        check({tag, ":early_valid"}, 64'(early), 64'(0));
        check({tag, ":valid"}, 64'(result_valid), 64'(1));
        check({tag, ":busy_done"}, 64'(busy), 64'(0));
        check({tag, ":result"}, 64'(result), 64'(exp));
        last_exp = exp;
    endtask

    // Leave DONE without a start: valid drops, result holds.
    task automatic finish_idle(input string tag);
        start       = 1'b0;
        slice_valid = 1'b1;
        scramble_inputs();
        tick();
        slice_valid = 1'b0;
        check({tag, ":valid_drop"}, 64'(result_valid), 64'(0));
        check({tag, ":hold"}, 64'(result), 64'(last_exp));
        check({tag, ":idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b1;
        start       = 1'b0;
        slice_valid = 1'b0;
        offset      = '0;
        scramble_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst:busy", 64'(busy), 64'(0));
        check("rst:valid", 64'(result_valid), 64'(0));
        check("rst:result", 64'(result), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        fill(0);
        run_op(32'h0, -1, 0, 1'b0, "zero");
        check("zero:const", 64'(result), 64'(0));
        finish_idle("zero");

        fill(0);
        run_op(32'h0001_0000, -1, 0, 1'b0, "offs");
        check("offs:const", 64'(result), 64'(2));
        finish_idle("offs");

        fill(0);
        sl[B-1][0] = 32'd5;
        run_op(32'h0, -1, 0, 1'b0, "msb5");
        check("msb5:const", 64'(result), 64'(40'hFF_FFFF_FFFB));
        finish_idle("msb5");

        fill(0);
        for (int i = 0; i < 8; i++) sl[B-1][i] = 32'h8000_0000;
        run_op(32'h0, -1, 0, 1'b0, "minmsb");
        check("minmsb:const", 64'(result), 64'(40'h04_0000_0000));
        finish_idle("minmsb");

        fill(1);
        run_op($urandom, 7, 3, 1'b1, "stall");
        finish_idle("stall");

        // Random runs; some back-to-back with start during DONE.
        for (int n = 0; n < 8; n++) begin
            fill((n % 3 == 0) ? 2 : 1);
            run_op($urandom, int'($urandom_range(0, B - 1)), int'($urandom_range(0, 2)),
                   n[0], "rnd");
            if (n % 3 == 2) finish_idle("rnd");
        end
        finish_idle("rnd_end");

        // Reset mid-accumulation, then keep feeding slices without start.
        fill(1);
        start  = 1'b1;
        offset = $urandom;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            slice_valid = 1'b1;
            d           = sl[k];
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst:busy", 64'(busy), 64'(0));
        check("midrst:valid", 64'(result_valid), 64'(0));
        check("midrst:result", 64'(result), 64'(0));
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < int'(B) + 4; k++) begin
            slice_valid = 1'b1;
            scramble_inputs();
            tick();
            if (result_valid || busy) seen = 1'b1;
        end
        slice_valid = 1'b0;
        check("midrst:no_valid", 64'(seen), 64'(0));

        fill(1);
        run_op($urandom, -1, 0, 1'b0, "recover");
        finish_idle("recover");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
